// File: rtl/snk_input_mapper.sv
// SNK triple-Z80 input front end: joystick mapping, coin shaping, DIP and game latches.
// Optional autofire on shot is enabled with `define SNK_INPUT_AUTOFIRE_EN.
module snk_input_mapper #(
  parameter int NUM_PLAYERS    = 2,
  parameter int DSW_BANKS      = 8,
  parameter int COIN_PULSE_CYC = 536000,
  parameter int AUTOFIRE_DIV   = 2680000
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [16*NUM_PLAYERS-1:0] joystick,
  input  logic                      ioctl_wr,
  input  logic [7:0]                ioctl_index,
  input  logic [24:0]               ioctl_addr,
  input  logic [7:0]                ioctl_dout,
  output logic [16*NUM_PLAYERS-1:0] player,
  output logic [8*DSW_BANKS-1:0]    dsw,
  output logic [7:0]                game,
  output logic                      pause_req
);

  localparam int CW = $clog2(COIN_PULSE_CYC + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(COIN_PULSE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    WAIT_REL
  } coin_state_t;

  logic [16*NUM_PLAYERS-1:0] joy_q;
  logic [NUM_PLAYERS-1:0]    coin_prev;
  coin_state_t               st_q [NUM_PLAYERS];
  coin_state_t               st_d [NUM_PLAYERS];
  logic [CW-1:0]             cnt_q [NUM_PLAYERS];
  logic [CW-1:0]             cnt_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]    coin_n;
  logic [NUM_PLAYERS-1:0]    shot_n;
  logic [16*NUM_PLAYERS-1:0] word_d;
  logic                      pause_d;
  logic                      unused_hi;

  // Opposing directions cancel; j excludes the unmapped upper nibble.
  function automatic logic [15:0] map_word(
    input logic [11:0] j,
    input logic        c_n,
    input logic        s_n
  );
    logic up_n, dn_n, rt_n, lf_n;
    logic unused_f;
    up_n = ~(j[3] & ~j[2]);
    dn_n = ~(j[2] & ~j[3]);
    rt_n = ~(j[0] & ~j[1]);
    lf_n = ~(j[1] & ~j[0]);
    unused_f = j[4] ^ j[8] ^ j[9];
    return {2'b11, up_n, dn_n, rt_n, lf_n, ~j[10], ~j[11],
            3'b111, ~j[6], ~j[5], s_n, ~j[7], c_n};
  endfunction

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      joy_q     <= '0;
      coin_prev <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        st_q[p]  <= IDLE;
        cnt_q[p] <= '0;
      end
    end else begin
      joy_q <= joystick;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        coin_prev[p] <= joy_q[16*p+8];
        st_q[p]      <= st_d[p];
        cnt_q[p]     <= cnt_d[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      st_d[p]  = st_q[p];
      cnt_d[p] = cnt_q[p];
      unique case (st_q[p])
        IDLE: begin
          if (joy_q[16*p+8] && !coin_prev[p]) begin
            st_d[p]  = PULSE;
            cnt_d[p] = CNT_LOAD;
          end
        end
        PULSE: begin
          if (cnt_q[p] == '0) st_d[p] = WAIT_REL;
          else cnt_d[p] = cnt_q[p] - CW'(1);
        end
        WAIT_REL: begin
          if (!joy_q[16*p+8]) st_d[p] = IDLE;
        end
        default: st_d[p] = IDLE;
      endcase
      // Driven from next state so the output register meets the 2-cycle latency.
      coin_n[p] = (st_d[p] != PULSE);
    end
  end

`ifdef SNK_INPUT_AUTOFIRE_EN
  localparam int AW = $clog2(AUTOFIRE_DIV + 1);

  logic [AW-1:0]          af_cnt_q [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] af_ph_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      af_ph_q <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) af_cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (!joy_q[16*p+4]) begin
          af_cnt_q[p] <= '0;
          af_ph_q[p]  <= 1'b0;
        end else if (af_cnt_q[p] == AW'(AUTOFIRE_DIV - 1)) begin
          af_cnt_q[p] <= '0;
          af_ph_q[p]  <= ~af_ph_q[p];
        end else begin
          af_cnt_q[p] <= af_cnt_q[p] + AW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++)
      shot_n[p] = ~(joy_q[16*p+4] & ~af_ph_q[p]);
  end
`else
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++)
      shot_n[p] = ~joy_q[16*p+4];
  end
`endif

  always_comb begin
    word_d    = '1;
    pause_d   = 1'b0;
    unused_hi = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      word_d[16*p +: 16] = map_word(joy_q[16*p +: 12], coin_n[p], shot_n[p]);
      pause_d   = pause_d | joy_q[16*p+9];
      unused_hi = unused_hi ^ (^joy_q[16*p+12 +: 4]);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      player    <= '1;
      pause_req <= 1'b0;
    end else begin
      player    <= word_d;
      pause_req <= pause_d;
    end
  end

  logic dsw_we;
  logic game_we;

  assign dsw_we = ioctl_wr && (ioctl_index == 8'd254) &&
                  (ioctl_addr[24:3] == 22'd0) &&
                  ({1'b0, ioctl_addr[2:0]} < 4'(DSW_BANKS));
  assign game_we = ioctl_wr && (ioctl_index == 8'd1) &&
                   (ioctl_addr == 25'd0);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dsw  <= '0;
      game <= '0;
    end else begin
      if (dsw_we) dsw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      if (game_we) game <= ioctl_dout;
    end
  end

endmodule

// File: tb/tb_snk_input_mapper.sv
// Directed bench for snk_input_mapper: reset, mapping, SOCD, coin shaper, DIP and game latches.
module tb_snk_input_mapper;

  localparam int NP = 2;
  localparam int NB = 8;
  localparam int CP = 8;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [31:0]   joystick;
  logic          ioctl_wr;
  logic [7:0]    ioctl_index;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic [31:0]   player;
  logic [63:0]   dsw;
  logic [7:0]    game;
  logic          pause_req;

  int n_vec = 0;
  int n_bad = 0;

  snk_input_mapper #(
    .NUM_PLAYERS(NP),
    .DSW_BANKS(NB),
    .COIN_PULSE_CYC(CP),
    .AUTOFIRE_DIV(4)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .joystick(joystick),
    .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .player(player),
    .dsw(dsw),
    .game(game),
    .pause_req(pause_req)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Observe P1 coin bit for ncyc negedges after the stimulus negedge.
  task automatic coin_run(input int ncyc, output int first,
                          output int lows, output int falls);
    logic prev;
    first = -1;
    lows  = 0;
    falls = 0;
    prev  = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk_sys);
      if (player[0] == 1'b0) begin
        lows++;
        if (first < 0) first = i;
        if (prev) falls++;
      end
      prev = player[0];
    end
  endtask

  task automatic ioctl_write(input logic [7:0] idx, input logic [24:0] a,
                             input logic [7:0] d, input logic wr);
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = wr;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  int first, lows, falls;

  initial begin
    reset       = 1'b1;
    joystick    = '0;
    ioctl_wr    = 1'b0;
    ioctl_index = '0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_player", 64'(player), 64'hFFFF_FFFF);
    chk("rst_dsw", dsw, 64'h0);
    chk("rst_game", 64'(game), 64'h0);
    chk("rst_pause", 64'(pause_req), 64'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("idle_player", 64'(player), 64'hFFFF_FFFF);

    // Direction latency: P1 up
    joystick = 32'h0000_0008;
    @(negedge clk_sys);
    chk("up_lat1", 64'(player[15:0]), 64'hFFFF);
    @(negedge clk_sys);
    chk("up_lat2", 64'(player[15:0]), 64'hDFFF);

    // P1 right + service, start2, armor, missile, shot, start1
    joystick = 32'h0000_0CF1;
    repeat (2) @(negedge clk_sys);
    chk("p1_buttons", 64'(player[15:0]), 64'hF4E1);

    // SOCD on P2: up+down+left
    joystick = 32'h000E_0000;
    repeat (2) @(negedge clk_sys);
    chk("socd_p2", 64'(player[31:16]), 64'hFBFF);
    chk("socd_p1", 64'(player[15:0]), 64'hFFFF);

    // Left+right cancel on P1
    joystick = 32'h0000_0003;
    repeat (2) @(negedge clk_sys);
    chk("socd_lr", 64'(player[15:0]), 64'hFFFF);

    // Pause from P2
    joystick = 32'h0200_0000;
    repeat (2) @(negedge clk_sys);
    chk("pause_on", 64'(pause_req), 64'h1);
    chk("pause_word", 64'(player[31:16]), 64'hFFFF);
    joystick = '0;
    repeat (2) @(negedge clk_sys);
    chk("pause_off", 64'(pause_req), 64'h0);

    // Coin held 50 cycles: single 8-cycle pulse at latency 2
    joystick = 32'h0000_0100;
    coin_run(50, first, lows, falls);
    chk("coin1_first", 64'(first), 64'd2);
    chk("coin1_len", 64'(lows), 64'd8);
    chk("coin1_count", 64'(falls), 64'd1);
    joystick = '0;
    repeat (3) @(negedge clk_sys);
    joystick = 32'h0000_0100;
    coin_run(20, first, lows, falls);
    chk("coin2_first", 64'(first), 64'd2);
    chk("coin2_len", 64'(lows), 64'd8);
    joystick = '0;
    repeat (3) @(negedge clk_sys);

    // Release/re-press during pulse does not extend it
    joystick = 32'h0000_0100;
    repeat (3) @(negedge clk_sys);
    joystick = '0;
    @(negedge clk_sys);
    joystick = 32'h0000_0100;
    coin_run(20, first, lows, falls);
    chk("coin_repress_len", 64'(lows), 64'd5);
    joystick = '0;
    repeat (3) @(negedge clk_sys);

    // DIP writes
    ioctl_write(8'd254, 25'd1, 8'h5A, 1'b1);
    chk("dsw_b1", dsw, 64'h0000_0000_0000_5A00);
    ioctl_write(8'd254, 25'd12, 8'h33, 1'b1);
    chk("dsw_addr12", dsw, 64'h0000_0000_0000_5A00);
    ioctl_write(8'd254, 25'd7, 8'hC3, 1'b1);
    chk("dsw_b7", dsw, 64'hC300_0000_0000_5A00);
    ioctl_write(8'd253, 25'd2, 8'h11, 1'b1);
    chk("dsw_bad_idx", dsw, 64'hC300_0000_0000_5A00);

    // Game latch
    ioctl_write(8'd1, 25'd0, 8'h02, 1'b0);
    @(negedge clk_sys);
    chk("game_nowr", 64'(game), 64'h00);
    ioctl_write(8'd1, 25'd0, 8'h02, 1'b1);
    chk("game_wr", 64'(game), 64'h02);
    ioctl_write(8'd1, 25'd1, 8'h07, 1'b1);
    chk("game_addr1", 64'(game), 64'h02);

    // Reset at pulse cycle 3 with coin held
    joystick = 32'h0000_0100;
    repeat (4) @(negedge clk_sys);
    chk("mp_low", 64'(player[0]), 64'h0);
    reset = 1'b1;
    #1;
    chk("mp_async", 64'(player[0]), 64'h1);
    repeat (2) @(negedge clk_sys);
    chk("mp_dsw_clr", dsw, 64'h0);
    reset = 1'b0;
    coin_run(20, first, lows, falls);
    chk("mp_first", 64'(first), 64'd2);
    chk("mp_len", 64'(lows), 64'd8);
    chk("mp_count", 64'(falls), 64'd1);
    joystick = '0;
    repeat (2) @(negedge clk_sys);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
